// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   state_t     receiver FSM states
//   DATA_BITS   payload bits per frame
//   FRAME_BITS  start + data + parity + stop
//   parity_bit  parity bit a transmitter appends to a byte
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } state_t;

    // odd_neven = 1 gives odd parity: data plus parity bit holds an odd number of ones.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd_neven);
        return (^data) ^ odd_neven;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous single-bit input.
//   clk    in  sampling clock
//   rst_n  in  synchronous active-low reset; both flops load RST_VAL
//   d      in  asynchronous input
//   q      out synchronised copy of d, two clk cycles late
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, start + 8 data bits (LSB first) + parity + stop.
// Each bit is sampled once at its middle, timed from the synchronised falling
// edge of the start bit.
//   UART_clk      in  clock at OVERSAMPLE x baud
//   rst_n         in  synchronous active-low reset
//   rx            in  asynchronous serial line, idle high
//   data_out      out last received byte, held until the next done tick
//   rx_done_tick  out one-cycle pulse per frame, error frames included
//   parity_err    out parity mismatch on last frame
//   frame_err     out stop bit was 0 on last frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int ODD_nEVEN  = 1
) (
    input  logic                 UART_clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done_tick,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int         SW       = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic       ODD_BIT  = (ODD_nEVEN != 0);

    logic rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (UART_clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    state_t               state_q,  state_d;
    logic [SW-1:0]        s_q,      s_d;
    logic [2:0]           n_q,      n_d;
    logic [DATA_BITS-1:0] shreg_q,  shreg_d;
    logic                 pbit_q,   pbit_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 done_q,   done_d;
    logic                 perr_q,   perr_d;
    logic                 ferr_q,   ferr_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        pbit_d  = pbit_q;
        data_d  = data_q;
        done_d  = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            // Mid start bit: confirms the start and fixes the sampling phase
            // for the rest of the frame (each later sample is one full bit on).
            START: begin
                if (s_q == S_HALF) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end
                end else begin
                    s_d = s_q + SW'(1);
                end
            end

            DATA: begin
                if (s_q == S_LAST) begin
                    s_d     = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (n_q == 3'd7) state_d = PARITY;
                    else             n_d     = n_q + 3'd1;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end

            PARITY: begin
                if (s_q == S_LAST) begin
                    s_d     = '0;
                    pbit_d  = rx_s;
                    state_d = STOP;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end

            // Results load together with the tick, so they stay coherent
            // with it and hold until the next frame completes.
            STOP: begin
                if (s_q == S_LAST) begin
                    s_d     = '0;
                    done_d  = 1'b1;
                    data_d  = shreg_q;
                    perr_d  = (pbit_q != parity_bit(shreg_q, ODD_BIT));
                    ferr_d  = ~rx_s;
                    state_d = rx_s ? IDLE : BRK;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end

            // A line stuck low after a bad stop bit must not start a new frame.
            BRK: begin
                if (rx_s) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge UART_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            pbit_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            pbit_q  <= pbit_d;
            data_q  <= data_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out     = data_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at OVERSAMPLE=16, odd parity.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    uart_rx #(.OVERSAMPLE(OS), .ODD_nEVEN(1)) dut (
        .UART_clk     (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data_out     (data_out),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick log: cycle stamp and outputs captured at each done tick.
    int         tick_cnt = 0;
    int         tk_cyc [64];
    logic [7:0] tk_dat [64];
    logic       tk_pe  [64];
    logic       tk_fe  [64];

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            if (tick_cnt < 64) begin
                tk_cyc[tick_cnt] = cyc;
                tk_dat[tick_cnt] = data_out;
                tk_pe[tick_cnt]  = parity_err;
                tk_fe[tick_cnt]  = frame_err;
            end
            tick_cnt = tick_cnt + 1;
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic st);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(st);
    endtask

    task automatic chk_tick(input string tag, input int idx, input logic [7:0] d,
                            input logic pe, input logic fe);
        logic [7:0] gd;
        logic       gp, gf;
        gd = 'x; gp = 1'bx; gf = 1'bx;
        if (idx < tick_cnt && idx < 64) begin
            gd = tk_dat[idx]; gp = tk_pe[idx]; gf = tk_fe[idx];
        end
        chk({tag, "_data"}, 32'(gd), 32'(d));
        chk({tag, "_perr"}, 32'(gp), 32'(pe));
        chk({tag, "_ferr"}, 32'(gf), 32'(fe));
    endtask

    int base;
    int t0;

    initial begin
        // Reset state
        idle(3);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_tick", 32'(rx_done_tick), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        idle(10);

        // 1: single good frame; latency = 2 sync + 169 cycles from rx falling
        base = tick_cnt; t0 = cyc;
        send_frame(8'h55, 1'b1, 1'b1);
        idle(20);
        chk("t1_count", 32'(tick_cnt - base), 32'd1);
        chk_tick("t1", base, 8'h55, 1'b0, 1'b0);
        chk("t1_lat", 32'(tk_cyc[base] - t0), 32'd171);
        chk("t1_hold", 32'(data_out), 32'h55);

        // 2: back-to-back, no idle gap
        base = tick_cnt;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'hA7, 1'b0, 1'b1);
        idle(20);
        chk("t2_count", 32'(tick_cnt - base), 32'd3);
        chk_tick("t2a", base,     8'h00, 1'b0, 1'b0);
        chk_tick("t2b", base + 1, 8'hFF, 1'b0, 1'b0);
        chk_tick("t2c", base + 2, 8'hA7, 1'b0, 1'b0);
        chk("t2_gap1", 32'(tk_cyc[base + 1] - tk_cyc[base]),     32'd176);
        chk("t2_gap2", 32'(tk_cyc[base + 2] - tk_cyc[base + 1]), 32'd176);

        // 3: parity error, then cleared by a good frame
        base = tick_cnt;
        send_frame(8'hA7, 1'b1, 1'b1);
        idle(20);
        chk("t3_count", 32'(tick_cnt - base), 32'd1);
        chk_tick("t3_bad", base, 8'hA7, 1'b1, 1'b0);
        chk("t3_hold_perr", 32'(parity_err), 32'h1);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(20);
        chk_tick("t3_good", base + 1, 8'h55, 1'b0, 1'b0);

        // 4: framing error followed by a held-low line
        base = tick_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        rx = 1'b0;
        idle(64);
        rx = 1'b1;
        idle(40);
        chk("t4_count", 32'(tick_cnt - base), 32'd1);
        chk_tick("t4_bad", base, 8'h3C, 1'b0, 1'b1);
        chk("t4_hold_ferr", 32'(frame_err), 32'h1);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(20);
        chk("t4_count2", 32'(tick_cnt - base), 32'd2);
        chk_tick("t4_good", base + 1, 8'h3C, 1'b0, 1'b0);

        // 5: 4-cycle glitch rejected, then a normal frame with normal latency
        base = tick_cnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        chk("t5_noglitch", 32'(tick_cnt - base), 32'd0);
        chk("t5_hold", 32'(data_out), 32'h3C);
        t0 = cyc;
        send_frame(8'h81, 1'b1, 1'b1);
        idle(20);
        chk("t5_count", 32'(tick_cnt - base), 32'd1);
        chk_tick("t5", base, 8'h81, 1'b0, 1'b0);
        chk("t5_lat", 32'(tk_cyc[base] - t0), 32'd171);

        // 6: reset in the middle of data bit 3 of 0xAA
        base = tick_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        idle(8);
        rst_n = 1'b0;
        idle(2);
        chk("t6_rst_data", 32'(data_out), 32'h00);
        chk("t6_rst_tick", 32'(rx_done_tick), 32'h0);
        chk("t6_rst_perr", 32'(parity_err), 32'h0);
        chk("t6_rst_ferr", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        rx = 1'b1;
        idle(200);
        chk("t6_notick", 32'(tick_cnt - base), 32'd0);
        chk("t6_data_clr", 32'(data_out), 32'h00);
        t0 = cyc;
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(20);
        chk("t6_count", 32'(tick_cnt - base), 32'd1);
        chk_tick("t6", base, 8'h5A, 1'b0, 1'b0);
        chk("t6_lat", 32'(tk_cyc[base] - t0), 32'd171);
        chk("t6_hold", 32'(data_out), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
